shot_resolver: RTL and testbench

SHOT_RESOLVER -- requirements
Module: shot_resolver

---
 rtl/shot_resolver_pkg.sv | 39 +++
 rtl/shot_resolver_rise_detect.sv | 37 +++
 rtl/shot_resolver.sv | 190 +++++++++++++++++++
 tb/tb_shot_resolver.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_resolver_pkg.sv
// ============================================================================
// shot_resolver_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the shot resolver block:
//   - state_t          : resolver FSM state encoding
//   - SHIP_MIN_STATE   : smallest ship_state whose full three-LED body is on
//                        the LED strip (lower values cannot produce a hit)
//   - SHIP_WIDTH       : number of LEDs the spaceship occupies
//   - LED_COUNT        : width of the LED strip / shot column indicator
//   - ship_covers()    : true when a column lies inside the ship body
// ============================================================================
package shot_resolver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLIGHT  = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam int SHIP_MIN_STATE = 2;
    localparam int SHIP_WIDTH     = 3;
    localparam int LED_COUNT      = 16;

    // The ship spans ship-(SHIP_WIDTH-1) .. ship. Arithmetic is done in int so
    // that ship values below SHIP_MIN_STATE never wrap around to high columns;
    // those values are rejected outright.
    function automatic logic ship_covers(input logic [3:0] ship,
                                         input logic [3:0] col);
        int s;
        int c;
        s = int'({28'd0, ship});
        c = int'({28'd0, col});
        return (s >= SHIP_MIN_STATE) &&
               (c >= s - (SHIP_WIDTH - 1)) &&
               (c <= s);
    endfunction

endpackage : shot_resolver_pkg

// File: rtl/shot_resolver_rise_detect.sv
// ============================================================================
// rise_detect
// ----------------------------------------------------------------------------
// One-bit rising-edge detector. The previous value of the input is held in a
// register; rise_o is high in any cycle where the input is 1 and was 0 in the
// previous cycle. The history register is cleared by reset, so an input that
// is already high when reset is released reports one edge on the first
// post-reset cycle.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (clears history to 0)
//   sig_i   in   level input, already synchronised to clk
//   rise_o  out  combinational edge flag (sig_i & ~history)
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule : rise_detect

// File: rtl/shot_resolver.sv
// ============================================================================
// shot_resolver
// ----------------------------------------------------------------------------
// Resolves player shots against a moving three-LED spaceship.
//
// A rising edge on fire in IDLE (with shots remaining) latches the aimed
// column, spends one shot and launches it. The shot is in flight for
// SHOT_CYCLES cycles (busy=1), then spends one RESOLVE cycle in which the
// current ship position is sampled and a one-cycle hit or miss pulse is
// produced. The score register takes the hit on the following edge. The game
// ends (OVER) once the score reaches WIN_SCORE or no shots are left; OVER
// holds until reset.
//
// Parameters:
//   SHOT_CYCLES  clk cycles a shot is in flight (>= 1)
//   MAX_SHOTS    shots per game (1..15)
//   WIN_SCORE    hits needed to win (1..MAX_SHOTS)
//
// Ports:
//   clk         in   1   system clock
//   rst         in   1   synchronous active-high reset
//   ship_state  in   4   leftmost lit LED of the ship (ship covers -2..0)
//   fire        in   1   fire button level, already synchronised
//   aim         in   4   LED column the player targets
//   score       out  8   hits so far (saturates at 255)
//   hit         out  1   one-cycle pulse during RESOLVE on a hit
//   miss        out  1   one-cycle pulse during RESOLVE on a miss
//   shots_left  out  4   remaining shots
//   busy        out  1   high while a shot is in flight
//   game_over   out  1   high in OVER
//   win         out  1   high in OVER when score >= WIN_SCORE
//   shot_led    out  16  shot column indicator
//
// Configuration:
//   SHOT_TRAIL_EN  when defined, shot_led is one-hot at the latched aim column
//                  during FLIGHT and RESOLVE. When undefined, shot_led is tied
//                  to 0 and no trail logic exists.
// ============================================================================
module shot_resolver
    import shot_resolver_pkg::*;
#(
    parameter int SHOT_CYCLES = 25000000,
    parameter int MAX_SHOTS   = 10,
    parameter int WIN_SCORE   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           ship_state,
    input  logic                 fire,
    input  logic [3:0]           aim,
    output logic [7:0]           score,
    output logic                 hit,
    output logic                 miss,
    output logic [3:0]           shots_left,
    output logic                 busy,
    output logic                 game_over,
    output logic                 win,
    output logic [LED_COUNT-1:0] shot_led
);

    // Flight counter width; a one-cycle flight still needs a 1-bit counter.
    localparam int              CNT_W      = (SHOT_CYCLES > 1) ? $clog2(SHOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SHOT_CYCLES - 1);
    localparam logic [7:0]       WIN_SCORE_L = 8'(WIN_SCORE);
    localparam logic [3:0]       MAX_SHOTS_L = 4'(MAX_SHOTS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       aim_q,   aim_d;
    logic [7:0]       score_q, score_d;
    logic [3:0]       left_q,  left_d;

    logic fire_rise;
    logic shot_hits;

    rise_detect u_fire_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (fire),
        .rise_o (fire_rise)
    );

    // The ship is sampled live; only the RESOLVE cycle acts on this value.
    assign shot_hits = ship_covers(ship_state, aim_q);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        aim_d   = aim_q;
        score_d = score_q;
        left_d  = left_q;
        hit     = 1'b0;
        miss    = 1'b0;
        busy    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Edges seen in any other state are simply dropped; the edge
                // detector keeps running so nothing is queued for later.
                if (fire_rise && (left_q != 4'd0)) begin
                    aim_d   = aim;
                    left_d  = left_q - 4'd1;
                    cnt_d   = '0;
                    state_d = ST_FLIGHT;
                end
            end

            ST_FLIGHT: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESOLVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESOLVE: begin
                if (shot_hits) begin
                    hit = 1'b1;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end else begin
                    miss = 1'b1;
                end
                // Game-end decision uses the score as it will be after this hit.
                if ((score_d >= WIN_SCORE_L) || (left_q == 4'd0)) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_OVER: begin
                // Terminal: everything holds until reset.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers; reset also discards any shot that is in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            aim_q   <= 4'd0;
            score_q <= 8'd0;
            left_q  <= MAX_SHOTS_L;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aim_q   <= aim_d;
            score_q <= score_d;
            left_q  <= left_d;
        end
    end

    // ------------------------------------------------------------------------
    // Registered-state outputs
    // ------------------------------------------------------------------------
    assign score      = score_q;
    assign shots_left = left_q;
    assign game_over  = (state_q == ST_OVER);
    assign win        = (state_q == ST_OVER) && (score_q >= WIN_SCORE_L);

`ifdef SHOT_TRAIL_EN
    logic shot_visible;
    assign shot_visible = (state_q == ST_FLIGHT) || (state_q == ST_RESOLVE);

    always_comb begin
        shot_led = '0;
        if (shot_visible) begin
            shot_led[aim_q] = 1'b1;
        end
    end
`else
    assign shot_led = '0;
`endif

endmodule : shot_resolver

// File: tb/tb_shot_resolver.sv
// ============================================================================
// tb_shot_resolver
// ----------------------------------------------------------------------------
// Self-checking bench for shot_resolver (SHOT_CYCLES=4, MAX_SHOTS=3,
// WIN_SCORE=2). A game-level model tracks score, shots, the age of the shot
// in flight and whether the game is over; every cycle its expectations are
// compared with the DUT outputs. Directed scenarios add hand-computed checks,
// followed by a randomized phase.
// ============================================================================
module tb_shot_resolver;

    localparam int SC = 4;
    localparam int MS = 3;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fire;
    logic [3:0]  ship_state;
    logic [3:0]  aim;
    logic [7:0]  score;
    logic        hit;
    logic        miss;
    logic [3:0]  shots_left;
    logic        busy;
    logic        game_over;
    logic        win;
    logic [15:0] shot_led;

    always #5 clk = ~clk;

    shot_resolver #(
        .SHOT_CYCLES (SC),
        .MAX_SHOTS   (MS),
        .WIN_SCORE   (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ship_state (ship_state),
        .fire       (fire),
        .aim        (aim),
        .score      (score),
        .hit        (hit),
        .miss       (miss),
        .shots_left (shots_left),
        .busy       (busy),
        .game_over  (game_over),
        .win        (win),
        .shot_led   (shot_led)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Game-level model: a shot is described by its age since launch; ages
    // 0..SC-1 are flight, age SC is the resolution cycle.
    // ------------------------------------------------------------------------
    bit m_valid  = 1'b0;
    int m_score  = 0;
    int m_left   = MS;
    bit m_over   = 1'b0;
    bit m_prev   = 1'b0;
    bit m_active = 1'b0;
    int m_age    = 0;
    int m_aim    = 0;

    always @(negedge clk) begin
        bit resolving;
        bit covered;
        bit edge_seen;
        int s;
        logic [15:0] e_led;

        s         = int'(ship_state);
        resolving = m_active && (m_age == SC);
        covered   = (s >= 2) && (m_aim >= s - 2) && (m_aim <= s);
        e_led     = 16'h0;
`ifdef SHOT_TRAIL_EN
        if (m_active) e_led = 16'h1 << m_aim;
`endif
        if (m_valid) begin
            check("m_busy",  busy,       m_active && (m_age < SC));
            check("m_hit",   hit,        resolving && covered);
            check("m_miss",  miss,       resolving && !covered);
            check("m_score", score,      m_score);
            check("m_left",  shots_left, m_left);
            check("m_over",  game_over,  m_over);
            check("m_win",   win,        m_over && (m_score >= WS));
            check("m_led",   shot_led,   e_led);
        end

        // Advance the model to what the next edge produces.
        if (rst) begin
            m_valid  = 1'b1;
            m_score  = 0;
            m_left   = MS;
            m_over   = 1'b0;
            m_prev   = 1'b0;
            m_active = 1'b0;
            m_age    = 0;
        end else begin
            edge_seen = fire && !m_prev;
            m_prev    = fire;
            if (resolving) begin
                if (covered && m_score < 255) m_score++;
                m_active = 1'b0;
                if (m_score >= WS || m_left == 0) m_over = 1'b1;
            end else if (m_active) begin
                m_age++;
            end else if (!m_over && edge_seen && m_left > 0) begin
                m_active = 1'b1;
                m_age    = 0;
                m_aim    = int'(aim);
                m_left--;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge; the
    // pulse counters sample on the falling edge.
    // ------------------------------------------------------------------------
    int n_hit, n_miss, n_busy;

    task automatic tick();
        @(negedge clk);
        n_hit  += int'(hit);
        n_miss += int'(miss);
        n_busy += int'(busy);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_hit  = 0;
        n_miss = 0;
        n_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    // One fire edge followed by enough idle cycles for flight and resolution.
    task automatic shoot(input logic [3:0] a, input logic [3:0] s);
        aim        = a;
        ship_state = s;
        fire       = 1'b1;
        tick();
        fire       = 1'b0;
        ticks(10);
    endtask

    initial begin
        rst        = 1'b1;
        fire       = 1'b0;
        aim        = 4'd0;
        ship_state = 4'd0;
        clear_counts();
        ticks(2);
        rst = 1'b0;

        // Reset state
        check("rst_score", score, 0);
        check("rst_left",  shots_left, 3);
        check("rst_flags", {hit, miss, busy, game_over, win}, 0);
        check("rst_led",   shot_led, 0);

        // Hit: aim 5 inside ship 4..6
        clear_counts();
        shoot(4'd5, 4'd6);
        check("hit_pulses",  n_hit, 1);
        check("hit_nomiss",  n_miss, 0);
        check("hit_busy",    n_busy, 4);
        check("hit_score",   score, 1);
        check("hit_left",    shots_left, 2);

        // Miss with ship_state=1 (no underflow into high columns)
        do_reset();
        clear_counts();
        shoot(4'd3, 4'd1);
        check("uf_miss",  n_miss, 1);
        check("uf_hit",   n_hit, 0);
        check("uf_score", score, 0);

        // Fire held 20 cycles -> one shot only
        do_reset();
        clear_counts();
        aim        = 4'd0;
        ship_state = 4'd0;
        fire       = 1'b1;
        ticks(20);
        fire       = 1'b0;
        ticks(8);
        check("hold_left",  shots_left, 2);
        check("hold_busy",  n_busy, 4);
        check("hold_shots", n_hit + n_miss, 1);

        // Ship moves away during flight -> miss
        do_reset();
        clear_counts();
        aim        = 4'd5;
        ship_state = 4'd6;
        fire       = 1'b1;
        tick();
        fire       = 1'b0;
        ship_state = 4'd10;
        ticks(10);
        check("move_miss", n_miss, 1);
        check("move_hit",  n_hit, 0);

        // Two hits -> win; later fire ignored
        do_reset();
        shoot(4'd5, 4'd6);
        shoot(4'd4, 4'd4);
        check("win_over",  game_over, 1);
        check("win_win",   win, 1);
        check("win_score", score, 2);
        clear_counts();
        shoot(4'd5, 4'd6);
        check("over_left", shots_left, 1);
        check("over_busy", n_busy, 0);
        check("over_hold", {game_over, win, score}, {1'b1, 1'b1, 8'd2});

        // Three misses -> lose
        do_reset();
        shoot(4'd3, 4'd1);
        shoot(4'd3, 4'd1);
        shoot(4'd0, 4'd15);
        check("lose_over", game_over, 1);
        check("lose_win",  win, 0);
        check("lose_left", shots_left, 0);

        // Reset mid-flight discards the shot
        do_reset();
        aim        = 4'd7;
        ship_state = 4'd7;
        fire       = 1'b1;
        tick();
        fire       = 1'b0;
        ticks(2);
        check("trail_busy", busy, 1);
`ifdef SHOT_TRAIL_EN
        check("trail_led", shot_led, 16'h0080);
`else
        check("trail_led", shot_led, 16'h0000);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",  busy, 0);
        check("mid_score", score, 0);
        check("mid_left",  shots_left, 3);
        clear_counts();
        ticks(8);
        check("mid_pulses", n_hit + n_miss, 0);

        // Fire held high through reset -> fires once on the first free cycle
        rst  = 1'b1;
        fire = 1'b1;
        ticks(2);
        rst  = 1'b0;
        tick();
        check("rel_busy", busy, 1);
        ticks(12);
        check("rel_left", shots_left, 2);
        fire = 1'b0;
        tick();

        // Randomized play with occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            fire       = ($urandom_range(0, 2) == 0);
            aim        = 4'($urandom_range(0, 15));
            ship_state = 4'($urandom_range(0, 15));
            tick();
        end
        rst  = 1'b0;
        fire = 1'b0;
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shot_resolver
